mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences the MEM stage of the 5-stage RV32 pipeline against a multi-cycle data memory that uses a req/ack handshake.
- Takes the load/store controls and operands from the EX/MEM pipeline register, drives the memory bus, and stalls the pipeline until the access completes or times out.
- Detects misaligned word accesses and bus timeouts, and returns load data to the writeback path.

Parameters:
- TIMEOUT_CYC, 16: max ACCESS cycles without mem_ack before abort; must be ≥2.
- CNT_W, 5: width of timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mem_read_i  in  1  load in MEM stage (ResultSrcM)
- mem_write_i  in  1  store in MEM stage (MemWriteM)
- addr_i  in  32  byte address (ALUResultM)
- wdata_i  in  32  store data (WriteDataM)
- mem_ack  in  1  memory completion, sampled only in ACCESS
- mem_rdata  in  32  memory read data, valid with mem_ack
- err_clr_i  in  1  clears sticky err_o
- mem_req  out  1  bus request (registered)
- mem_we  out  1  write enable (registered)
- mem_addr  out  32  latched word address (registered)
- mem_wdata  out  32  latched store data (registered)
- stall_o  out  1  freeze IF/ID/EX/MEM registers (combinational)
- rdata_o  out  32  load result (registered)
- rdata_valid_o  out  1  1-cycle pulse, rdata_o valid
- misalign_o  out  1  1-cycle pulse, misaligned access dropped
- err_o  out  1  sticky timeout flag

Behaviour:
Interface decisions:
- Clock clk.
- Reset rst, asynchronous, active-high.
- Reset values: state=IDLE and every output 0 (mem_req, mem_we, mem_addr, mem_wdata, rdata_o, rdata_valid_o, misalign_o, err_o, counter).
- stall_o=0 during reset.

Access definition:
- acc = mem_read_i | mem_write_i.
- If both are high, treat as a write.
- aligned = (addr_i[1:0]==2'b00).

States:
- IDLE:
  - acc & aligned: stall_o=1. At the clock edge: go to ACCESS; mem_req<=1, mem_we<=mem_write_i, mem_addr<={addr_i[31:2],2'b00}, mem_wdata<=wdata_i; counter<=0.
  - acc & !aligned: no request, stall_o=0, misalign_o<=1 for one cycle, stay in IDLE.
  - !acc: idle, stall_o=0.
- ACCESS:
  - stall_o=1 throughout.
  - mem_ack=1: mem_req<=0, mem_we<=0. If the access is a read, rdata_o<=mem_rdata. Go to DONE.
  - mem_ack=0: counter increments. When counter==TIMEOUT_CYC-1 with no ack: mem_req<=0, err_o<=1, rdata_o<=0, go to DONE.
- DONE:
  - stall_o=0. rdata_valid_o=1 only if the completed access was a read (including a timed-out read).
  - Pipeline advances at this edge. Next state is always IDLE.
  - Inputs in this cycle are ignored; no re-trigger.

Timing and boundary rules:
- Latency: fastest access (ack in the first ACCESS cycle) gives stall for 2 cycles (IDLE-detect plus ACCESS) and release in cycle 3.
- mem_addr, mem_wdata and mem_we are stable for the entire ACCESS period, independent of the inputs.
- mem_ack outside ACCESS is ignored.
- err_o clears on err_clr_i; when set and clear occur in the same cycle, set wins. Timeout does not block later accesses.
- Reset mid-ACCESS: mem_req drops asynchronously, state returns to IDLE, and no valid pulse is produced.
- Back-to-back accesses: DONE→IDLE→ACCESS, so there is a minimum 1-cycle gap (IDLE) between requests.

Test Plan:
- Load at addr 0x0000_0010, mem_ack on 1st ACCESS cycle with rdata 0xDEADBEEF → mem_req high 1 cycle, mem_addr=0x10, mem_we=0; stall_o high 2 cycles; next cycle rdata_valid_o=1, rdata_o=0xDEADBEEF.
- Store addr 0x20, wdata 0x12345678, ack after 3 cycles; inputs changed during wait → mem_we=1, mem_wdata=0x12345678 held until ack; stall_o high 4 cycles; no rdata_valid_o.
- Load addr 0x22 (misaligned) → mem_req never asserts, stall_o stays 0, misalign_o pulses 1 cycle.
- Load with no ack, TIMEOUT_CYC=16 → mem_req drops after 16 ACCESS cycles, err_o=1 sticky, rdata_o=0, rdata_valid_o pulses; err_clr_i pulse → err_o=0; a subsequent load completes normally.
- rst asserted during ACCESS wait → mem_req and stall_o go to 0 immediately; after release, an access to 0x40 runs normally.
- Two consecutive loads (0x4, then 0x8), immediate ack → two requests separated by a 1-cycle IDLE gap; two rdata_valid_o pulses with correct data; ack asserted in IDLE is ignored.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: issues one req/ack data-memory access per load/store,
// stalls the pipeline while it is outstanding, and flags misalignment and bus timeouts.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        err_clr_i,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misalign_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             is_read_r;
    logic             acc_s;
    logic             aligned_s;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

    // Decode the access request presented by the EX/MEM register.
    always_comb begin
        acc_s     = mem_read_i | mem_write_i;
        aligned_s = (addr_i[1:0] == 2'b00);
    end

    // Pipeline freeze: from the detecting IDLE cycle through the whole ACCESS wait.
    always_comb begin
        stall_o = 1'b0;
        if (rst) begin
            stall_o = 1'b0;
        end else begin
            case (state_r)
                IDLE:    stall_o = acc_s & aligned_s;
                ACCESS:  stall_o = 1'b1;
                DONE:    stall_o = 1'b0;
                default: stall_o = 1'b0;
            endcase
        end
    end

    // Access sequencer with registered bus and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            is_read_r     <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'h0000_0000;
            mem_wdata     <= 32'h0000_0000;
            rdata_o       <= 32'h0000_0000;
            rdata_valid_o <= 1'b0;
            misalign_o    <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            rdata_valid_o <= 1'b0;
            misalign_o    <= 1'b0;
            // A timeout later in this block overrides the clear (set wins).
            if (err_clr_i) begin
                err_o <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (acc_s && aligned_s) begin
                        state_r   <= ACCESS;
                        mem_req   <= 1'b1;
                        mem_we    <= mem_write_i;
                        is_read_r <= ~mem_write_i;
                        mem_addr  <= word_addr(addr_i);
                        mem_wdata <= wdata_i;
                        cnt_r     <= '0;
                    end else if (acc_s) begin
                        misalign_o <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req       <= 1'b0;
                        mem_we        <= 1'b0;
                        rdata_valid_o <= is_read_r;
                        if (is_read_r) begin
                            rdata_o <= mem_rdata;
                        end
                        state_r <= DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        mem_req       <= 1'b0;
                        mem_we        <= 1'b0;
                        err_o         <= 1'b1;
                        rdata_o       <= 32'h0000_0000;
                        rdata_valid_o <= is_read_r;
                        state_r       <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl; load results are checked against a
// queue of expected values whenever rdata_valid_o pulses.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err_clr_i;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        misalign_o;
    logic        err_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;

    mem_access_ctrl #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_clr_i(err_clr_i),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .misalign_o(misalign_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every load result pulse must match the oldest expected value.
    always @(negedge clk) begin
        if (rst === 1'b0 && rdata_valid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_valid rdata_o=%h expected no valid pulse", rdata_o);
            end else begin
                sb_exp = exp_q.pop_front();
                if (rdata_o !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_rdata got=%h expected=%h", rdata_o, sb_exp);
                end
            end
        end
    end

    task automatic clear_inputs();
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        addr_i      = 32'h0000_0000;
        wdata_i     = 32'h0000_0000;
        mem_ack     = 1'b0;
        err_clr_i   = 1'b0;
    endtask

    // Drives one access from an IDLE cycle and returns at the DONE cycle (negedge+1).
    // ack_after: ACCESS cycles before the acked one (-1 = never ack).
    task automatic run_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int ack_after, input logic [31:0] rdata, input bit scramble,
                              output int stall_cnt, output int req_cnt, output bit hold_ok);
        logic [31:0] waddr;
        waddr     = {addr[31:2], 2'b00};
        stall_cnt = 0;
        req_cnt   = 0;
        hold_ok   = 1'b1;
        mem_read_i  = ~wr;
        mem_write_i = wr;
        addr_i      = addr;
        wdata_i     = wdata;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (stall_o !== 1'b1) break;
            stall_cnt++;
            if (mem_req === 1'b1) begin
                req_cnt++;
                if (mem_addr !== waddr || mem_we !== wr || (wr && mem_wdata !== wdata))
                    hold_ok = 1'b0;
                if (ack_after >= 0 && req_cnt - 1 == ack_after) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end else begin
                    mem_rdata = $urandom;
                end
                if (scramble) begin
                    addr_i  = $urandom;
                    wdata_i = $urandom;
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        int s, r;
        rst = 1'b1;
        clear_inputs();
        mem_read_i = 1'b1;
        addr_i     = 32'h0000_0010;
        mem_ack    = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got=%b expected=0", stall_o);
        end
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, rdata_o, rdata_valid_o, misalign_o, err_o} !== 100'd0) begin
            errors++;
            $display("FAIL reset_outputs req=%b we=%b addr=%h wdata=%h rdata=%h v=%b mis=%b err=%b expected all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, rdata_o, rdata_valid_o, misalign_o, err_o);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load();
        int s, r;
        bit h;
        exp_q.push_back(32'hDEAD_BEEF);
        run_access(1'b0, 32'h0000_0010, 32'h0000_0000, 0, 32'hDEAD_BEEF, 1'b0, s, r, h);
        checks++;
        if (s != 2 || r != 1 || !h) begin
            errors++;
            $display("FAIL load_timing stall=%0d req=%0d hold=%0d expected 2 1 1", s, r, h);
        end
        checks++;
        if (mem_req !== 1'b0 || rdata_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL load_done req=%b valid=%b expected 0 1", mem_req, rdata_valid_o);
        end
        clear_inputs();
        @(negedge clk);
        #1;
        checks++;
        if (rdata_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL load_pulse_end valid=%b stall=%b expected 0 0", rdata_valid_o, stall_o);
        end
    endtask

    task automatic test_store();
        int s, r;
        bit h;
        run_access(1'b1, 32'h0000_0020, 32'h1234_5678, 2, 32'h0000_0000, 1'b1, s, r, h);
        checks++;
        if (s != 4 || r != 3 || !h) begin
            errors++;
            $display("FAIL store_timing stall=%0d req=%0d hold=%0d expected 4 3 1", s, r, h);
        end
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rdata_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_keeps_rdata got=%h expected=deadbeef", rdata_o);
        end
    endtask

    task automatic test_misalign();
        mem_read_i = 1'b1;
        addr_i     = 32'h0000_0022;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_stall got=%b expected=0", stall_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (misalign_o !== 1'b1 || mem_req !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse mis=%b req=%b stall=%b expected 1 0 0", misalign_o, mem_req, stall_o);
        end
        clear_inputs();
        @(negedge clk);
        #1;
        checks++;
        if (misalign_o !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL misalign_end mis=%b req=%b expected 0 0", misalign_o, mem_req);
        end
    endtask

    task automatic test_timeout();
        int s, r;
        bit h;
        exp_q.push_back(32'h0000_0000);
        run_access(1'b0, 32'h0000_0030, 32'h0000_0000, -1, 32'h0000_0000, 1'b0, s, r, h);
        checks++;
        if (s != 17 || r != 16 || !h) begin
            errors++;
            $display("FAIL timeout_timing stall=%0d req=%0d hold=%0d expected 17 16 1", s, r, h);
        end
        checks++;
        if (err_o !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err err=%b req=%b expected 1 0", err_o, mem_req);
        end
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky err=%b expected=1", err_o);
        end
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear err=%b expected=0", err_o);
        end
        exp_q.push_back(32'hCAFE_F00D);
        run_access(1'b0, 32'h0000_0034, 32'h0000_0000, 1, 32'hCAFE_F00D, 1'b0, s, r, h);
        checks++;
        if (s != 3 || r != 2 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL after_timeout stall=%0d req=%0d err=%b expected 3 2 0", s, r, err_o);
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_err_set_wins();
        int s, r;
        bit h;
        err_clr_i = 1'b1;
        exp_q.push_back(32'h0000_0000);
        run_access(1'b0, 32'h0000_0038, 32'h0000_0000, -1, 32'h0000_0000, 1'b0, s, r, h);
        checks++;
        if (err_o !== 1'b1 || s != 17) begin
            errors++;
            $display("FAIL err_set_wins err=%b stall=%0d expected 1 17", err_o, s);
        end
        mem_read_i = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_after err=%b expected=0", err_o);
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int s, r;
        bit h;
        mem_read_i = 1'b1;
        addr_i     = 32'h0000_0050;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid req=%b stall=%b expected 0 0", mem_req, stall_o);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(32'h4040_4040);
        run_access(1'b0, 32'h0000_0040, 32'h0000_0000, 0, 32'h4040_4040, 1'b0, s, r, h);
        checks++;
        if (s != 2 || r != 1 || !h) begin
            errors++;
            $display("FAIL reset_recover stall=%0d req=%0d hold=%0d expected 2 1 1", s, r, h);
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int s, r;
        bit h;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBADB_AD00;
        @(negedge clk);
        #1;
        checks++;
        if (stall_o !== 1'b0 || mem_req !== 1'b0 || rdata_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack stall=%b req=%b valid=%b expected 0 0 0", stall_o, mem_req, rdata_valid_o);
        end
        mem_ack = 1'b0;
        exp_q.push_back(32'h1111_0004);
        run_access(1'b0, 32'h0000_0004, 32'h0000_0000, 0, 32'h1111_0004, 1'b0, s, r, h);
        checks++;
        if (s != 2 || r != 1 || !h) begin
            errors++;
            $display("FAIL b2b_first stall=%0d req=%0d hold=%0d expected 2 1 1", s, r, h);
        end
        addr_i    = 32'h0000_0008;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBADB_AD01;
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap req=%b stall=%b expected 0 1", mem_req, stall_o);
        end
        exp_q.push_back(32'h2222_0008);
        run_access(1'b0, 32'h0000_0008, 32'h0000_0000, 0, 32'h2222_0008, 1'b0, s, r, h);
        checks++;
        if (s != 2 || r != 1 || !h) begin
            errors++;
            $display("FAIL b2b_second stall=%0d req=%0d hold=%0d expected 2 1 1", s, r, h);
        end
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        mem_rdata = 32'h0000_0000;
        clear_inputs();
        test_reset();
        test_load();
        test_store();
        test_misalign();
        test_timeout();
        test_err_set_wins();
        test_reset_mid_access();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
